dcm_ctrl: RTL and testbench
===========================

DCM_CTRL -- requirements
Module: dcm_ctrl

Interface
- REQ-001 RST_CYCLES, 4, cycles DCM_RST is held high per attempt; minimum legal value 3.
- REQ-002 LOCK_TIMEOUT, 24000, cycles allowed in WAIT_LOCK per attempt.
- REQ-003 SETTLE_CYCLES, 16, consecutive cycles of clean lock required before release.
- REQ-004 RETRY_MAX, 3, retries allowed after the first attempt before FAIL.
- REQ-005 CLKIN  in  1  DCM reference clock; the only clock of this block.
- REQ-006 RST_N  in  1  asynchronous, active-low reset.
- REQ-007 DCM_LOCKED  in  1  DCM LOCKED, asynchronous to CLKIN.
- REQ-008 DCM_STATUS  in  8  DCM STATUS; only bit 2 (CLKFX stopped) is used.
- REQ-009 FORCE_RESET  in  1  single-cycle software request to re-lock the DCM.
- REQ-010 DCM_RST  out  1  drives the DCM RST input.
- REQ-011 SYS_RST  out  1  active-high reset for logic on CLKFX; the consumer synchronizes it.
- REQ-012 CLK_GOOD  out  1  high only in RUN.
- REQ-013 FAIL  out  1  high only in FAIL.
- REQ-014 RETRY_CNT  out  3  number of retries in the current episode.

Function
- REQ-015 DCM_LOCKED and DCM_STATUS[2] SHALL each pass through a 2-flop synchronizer before use; the synchronized signals are lock_s and fxstop_s.
- REQ-016 "good" SHALL mean lock_s=1 and fxstop_s=0.
- REQ-017 The FSM SHALL have exactly five states: RESET_ASSERT, WAIT_LOCK, SETTLE, RUN, FAIL.
- REQ-018 All outputs SHALL be registered and decoded from the state, with no combinational path from inputs.
- REQ-019 RESET_ASSERT SHALL drive DCM_RST=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- REQ-020 WAIT_LOCK SHALL go to SETTLE on the first good cycle.
- REQ-021 WAIT_LOCK SHALL end the attempt after LOCK_TIMEOUT cycles without a good cycle.
- REQ-022 A failed attempt SHALL go to FAIL if RETRY_CNT=RETRY_MAX; otherwise it SHALL increment RETRY_CNT and go to RESET_ASSERT.
- REQ-023 SETTLE SHALL go to RUN after SETTLE_CYCLES consecutive good cycles.
- REQ-024 Any not-good cycle in SETTLE SHALL count as a failed attempt, handled as in REQ-022.
- REQ-025 In RUN, a not-good cycle SHALL clear RETRY_CNT (new episode) and go to RESET_ASSERT.
- REQ-026 FAIL SHALL be left only by FORCE_RESET or RST_N.
- REQ-027 In FAIL, DCM_RST SHALL be 0 and SYS_RST SHALL be 1.
- REQ-028 FORCE_RESET in any state SHALL clear RETRY_CNT and go to RESET_ASSERT.
- REQ-029 FORCE_RESET SHALL have priority over timeout, lock and lock-loss events in the same cycle.
- REQ-030 FORCE_RESET in RESET_ASSERT SHALL restart the RST_CYCLES count.
- REQ-031 SYS_RST SHALL be 0 only in RUN.
- REQ-032 CLK_GOOD SHALL rise exactly SETTLE_CYCLES+3 cycles after a clean DCM_LOCKED rise seen in WAIT_LOCK.
- REQ-033 SYS_RST SHALL rise no more than 3 cycles after DCM_LOCKED falls in RUN.
- REQ-034 A single down-counter, sized for max(LOCK_TIMEOUT, SETTLE_CYCLES, RST_CYCLES), SHALL be reloaded on every state entry.
- REQ-035 The counter SHALL never wrap.
- REQ-036 RETRY_CNT SHALL saturate at RETRY_MAX.

Reset
- REQ-037 RST_N low SHALL asynchronously force: state RESET_ASSERT, DCM_RST=1, SYS_RST=1, CLK_GOOD=0, FAIL=0, RETRY_CNT=0, synchronizer flops 0, counter=RST_CYCLES-1.
- REQ-038 After RST_N is released, the sequence SHALL start from REQ-019, including when RST_N was asserted mid-operation.

Structure
- REQ-039 The package dcm_ctrl_pkg SHALL hold the state encoding, the parameter defaults and the STATUS bit index constant (2).
- REQ-040 One sub-module, sync2 (2-flop synchronizer, async active-low reset), SHALL be instantiated twice.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, RETRY_MAX=3)
- REQ-041 Release RST_N, raise DCM_LOCKED at cycle 10 -> DCM_RST high for cycles 0-3; CLK_GOOD=1 and SYS_RST=0 from cycle 29; RETRY_CNT=0.
- REQ-042 DCM_LOCKED held low -> four DCM_RST pulses of 4 cycles each, 104 cycles apart; RETRY_CNT steps 1,2,3; FAIL=1 at cycle 416; DCM_RST=0 afterwards.
- REQ-043 In RUN, drop DCM_LOCKED -> SYS_RST=1 and CLK_GOOD=0 within 3 cycles, a 4-cycle DCM_RST pulse, RETRY_CNT=0.
- REQ-044 DCM_LOCKED drops for 5 cycles at SETTLE count 8 -> back to RESET_ASSERT with RETRY_CNT=1; CLK_GOOD does not pulse; RUN is reached after relock.
- REQ-045 FORCE_RESET in FAIL, and FORCE_RESET in the same cycle as a timeout -> RESET_ASSERT, FAIL=0, RETRY_CNT=0.
- REQ-046 RST_N low mid-WAIT_LOCK -> all outputs at reset values before the next CLKIN edge.

Source files
------------

// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM lock controller: state encoding, parameter
// defaults and the STATUS bit that flags a stopped CLKFX.
package dcm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_ASSERT = 3'd0,
    ST_WAIT_LOCK    = 3'd1,
    ST_SETTLE       = 3'd2,
    ST_RUN          = 3'd3,
    ST_FAIL         = 3'd4
  } state_e;

  localparam int unsigned RST_CYCLES_DEF    = 4;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 24000;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned RETRY_MAX_DEF     = 3;

  localparam int unsigned STATUS_FXSTOP_BIT = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous level into the clkin_i domain.
module sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_ctrl.sv
// DCM lock controller: pulses DCM reset, waits for a clean lock, retries a
// bounded number of times and holds the CLKFX domain in reset until stable.
module dcm_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned RETRY_MAX     = RETRY_MAX_DEF
) (
  input  logic       clkin_i,
  input  logic       rst_n_i,
  input  logic       dcm_locked_i,
  input  logic [7:0] dcm_status_i,
  input  logic       force_reset_i,
  output logic       dcm_rst_o,
  output logic       sys_rst_o,
  output logic       clk_good_o,
  output logic       fail_o,
  output logic [2:0] retry_cnt_o
);

  localparam int unsigned CNT_MAX = max3(LOCK_TIMEOUT, SETTLE_CYCLES, RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic lock_s;
  logic fxstop_s;
  logic good;
  logic status_unused;

  sync2 u_sync_lock (
    .clk_i   (clkin_i),
    .rst_n_i (rst_n_i),
    .d_i     (dcm_locked_i),
    .q_o     (lock_s)
  );

  sync2 u_sync_fxstop (
    .clk_i   (clkin_i),
    .rst_n_i (rst_n_i),
    .d_i     (dcm_status_i[STATUS_FXSTOP_BIT]),
    .q_o     (fxstop_s)
  );

  assign good          = lock_s & ~fxstop_s;
  assign status_unused = ^{dcm_status_i[7:3], dcm_status_i[1:0]};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             dcm_rst_q, sys_rst_q, clk_good_q, fail_q;
  logic             fail_attempt;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    fail_attempt = 1'b0;
    cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

    if (force_reset_i) begin
      state_d = ST_RESET_ASSERT;
      retry_d = 3'd0;
    end else begin
      case (state_q)
        ST_RESET_ASSERT: if (cnt_q == '0) state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (good)               state_d      = ST_SETTLE;
          else if (cnt_q == '0)   fail_attempt = 1'b1;
        end
        ST_SETTLE: begin
          if (!good)              fail_attempt = 1'b1;
          else if (cnt_q == '0)   state_d      = ST_RUN;
        end
        ST_RUN: begin
          if (!good) begin
            state_d = ST_RESET_ASSERT;
            retry_d = 3'd0;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RESET_ASSERT;
      endcase
    end

    if (fail_attempt) begin
      if (retry_q >= 3'(RETRY_MAX)) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_RESET_ASSERT;
        retry_d = retry_q + 3'd1;
      end
    end

    // Every entry, including a forced re-entry of RESET_ASSERT, starts a fresh count.
    if (force_reset_i || (state_d != state_q)) begin
      case (state_d)
        ST_RESET_ASSERT: cnt_d = CNT_W'(RST_CYCLES - 1);
        ST_WAIT_LOCK:    cnt_d = CNT_W'(LOCK_TIMEOUT - 1);
        ST_SETTLE:       cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        default:         cnt_d = '0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RESET_ASSERT;
      cnt_q      <= CNT_W'(RST_CYCLES - 1);
      retry_q    <= 3'd0;
      dcm_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      clk_good_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      dcm_rst_q  <= (state_d == ST_RESET_ASSERT);
      sys_rst_q  <= (state_d != ST_RUN);
      clk_good_q <= (state_d == ST_RUN);
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign clk_good_o  = clk_good_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_dcm_ctrl.sv
// Directed bench for dcm_ctrl with a short lock timeout; cycle n is sampled at
// the falling edge that follows the n-th rising edge after reset release.
module tb_dcm_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       locked = 1'b0;
  logic [7:0] status = 8'h00;
  logic       forceReset = 1'b0;
  logic       dcmRst, sysRst, clkGood, failO;
  logic [2:0] retryCnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dcm_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .SETTLE_CYCLES (16),
    .RETRY_MAX     (3)
  ) dut (
    .clkin_i       (clk),
    .rst_n_i       (rstN),
    .dcm_locked_i  (locked),
    .dcm_status_i  (status),
    .force_reset_i (forceReset),
    .dcm_rst_o     (dcmRst),
    .sys_rst_o     (sysRst),
    .clk_good_o    (clkGood),
    .fail_o        (failO),
    .retry_cnt_o   (retryCnt)
  );

  task automatic applyStimulus(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic cmpBit(input string tag, input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s cycle %0d observed %b expected %b", tag, name, cyc, obs, exp);
    end
  endtask

  // A negative expectation leaves that output unchecked at this point.
  task automatic checkOutput(input string tag, input int expDcm, input int expSys,
                             input int expGood, input int expFail, input int expRetry);
    if (expDcm >= 0)  cmpBit(tag, "dcm_rst", dcmRst, expDcm[0]);
    if (expSys >= 0)  cmpBit(tag, "sys_rst", sysRst, expSys[0]);
    if (expGood >= 0) cmpBit(tag, "clk_good", clkGood, expGood[0]);
    if (expFail >= 0) cmpBit(tag, "fail", failO, expFail[0]);
    if (expRetry >= 0) begin
      checks++;
      assert (retryCnt === expRetry[2:0]) else begin
        errors++;
        $error("[TB] FAIL %s.retry_cnt cycle %0d observed %0d expected %0d",
               tag, cyc, retryCnt, expRetry);
      end
    end
  endtask

  initial begin
    // Power-on reset.
    #1 rstN = 1'b0;
    #1 checkOutput("por", 1, 1, 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    cyc  = 0;
    #1 checkOutput("c0", 1, 1, 0, 0, 0);

    // First lock: DCM_LOCKED rises at cycle 10.
    applyStimulus(3);  checkOutput("rst_last", 1, 1, 0, 0, 0);
    applyStimulus(4);  checkOutput("wait_entry", 0, 1, 0, 0, 0);
    applyStimulus(10); locked = 1'b1;
    applyStimulus(28); checkOutput("pre_run", 0, 1, 0, 0, 0);
    applyStimulus(29); checkOutput("run", 0, 0, 1, 0, 0);

    // Lock loss in RUN at cycle 40, relock at 50.
    applyStimulus(40); locked = 1'b0;
    applyStimulus(42); checkOutput("loss_hold", 0, 0, 1, 0, 0);
    applyStimulus(43); checkOutput("loss_rst", 1, 1, 0, 0, 0);
    applyStimulus(46); checkOutput("loss_rst_end", 1, -1, -1, -1, -1);
    applyStimulus(47); checkOutput("loss_wait", 0, 1, 0, 0, 0);
    applyStimulus(50); locked = 1'b1;
    applyStimulus(68); checkOutput("relock_pre", -1, 1, 0, -1, -1);
    applyStimulus(69); checkOutput("relock_run", 0, 0, 1, 0, 0);

    // Forced re-lock from RUN, then a 5-cycle dropout at SETTLE count 8.
    applyStimulus(75); forceReset = 1'b1;
    applyStimulus(76); forceReset = 1'b0;
    checkOutput("force_run", 1, 1, 0, 0, 0);
    for (int c = 77; c <= 111; c++) begin
      applyStimulus(c);
      if (c == 88) locked = 1'b0;
      if (c == 93) locked = 1'b1;
      checkOutput("settle_no_good", -1, 1, 0, 0, -1);
      if (c == 80) checkOutput("force_wait", 0, -1, -1, -1, 0);
      if (c == 90) checkOutput("settle_hold", 0, -1, -1, -1, 0);
      if (c == 91) checkOutput("settle_retry", 1, -1, -1, -1, 1);
    end
    applyStimulus(112); checkOutput("settle_run", 0, 0, 1, 0, 1);

    // Stopped CLKFX: only STATUS bit 2 matters.
    applyStimulus(115); status = 8'hFB;
    applyStimulus(119); checkOutput("status_other_bits", 0, 0, 1, 0, 1);
    applyStimulus(120); status = 8'h04;
    applyStimulus(122); checkOutput("fxstop_hold", 0, 0, 1, 0, 1);
    applyStimulus(123); checkOutput("fxstop_rst", 1, 1, 0, 0, 0);
    applyStimulus(129); checkOutput("fxstop_wait", 0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of WAIT_LOCK.
    applyStimulus(130);
    rstN   = 1'b0;
    locked = 1'b0;
    #1 checkOutput("async_rst", 1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    status = 8'h00;
    rstN   = 1'b1;
    cyc    = 0;
    #1 checkOutput("rerelease", 1, 1, 0, 0, 0);

    // Lock never arrives: four attempts, then FAIL.
    for (int p = 0; p < 4; p++) begin
      if (p > 0) begin
        applyStimulus(104 * p - 1);
        checkOutput("timeout_gap", 0, 1, 0, 0, p - 1);
      end
      applyStimulus(104 * p);     checkOutput("pulse_start", 1, 1, 0, 0, p);
      applyStimulus(104 * p + 3); checkOutput("pulse_last", 1, -1, -1, -1, -1);
      applyStimulus(104 * p + 4); checkOutput("pulse_end", 0, -1, -1, -1, -1);
    end
    applyStimulus(415); checkOutput("pre_fail", 0, 1, 0, 0, 3);
    applyStimulus(416); checkOutput("fail", 0, 1, 0, 1, 3);
    applyStimulus(430); checkOutput("fail_stays", 0, 1, 0, 1, 3);

    // FORCE_RESET leaves FAIL.
    applyStimulus(440); forceReset = 1'b1;
    applyStimulus(441); forceReset = 1'b0;
    checkOutput("force_fail", 1, 1, 0, 0, 0);

    // FORCE_RESET coinciding with the timeout edge wins over the retry.
    applyStimulus(544); checkOutput("timeout_wait", 0, 1, 0, 0, 0);
    forceReset = 1'b1;
    applyStimulus(545); forceReset = 1'b0;
    checkOutput("force_timeout", 1, 1, 0, 0, 0);

    // FORCE_RESET inside RESET_ASSERT restarts the pulse count.
    applyStimulus(546); forceReset = 1'b1;
    applyStimulus(547); forceReset = 1'b0;
    applyStimulus(549); checkOutput("restart_mid", 1, -1, -1, -1, 0);
    applyStimulus(550); checkOutput("restart_last", 1, -1, -1, -1, -1);
    applyStimulus(551); checkOutput("restart_end", 0, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
